eager_fanout_fork: RTL and testbench

//  Parametrised ready/valid fanout fork for the interconnect: one source stream drives up to NUM_SINKS branches.

---
 rtl/eager_fanout_fork.sv | 143 ++++++++++++++
 tb/tb_eager_fanout_fork.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eager_fanout_fork.sv
`default_nettype none
// ============================================================================
//  Module   : eager_fanout_fork
//  Purpose  : Ready/valid fanout fork. One source stream is broadcast to up
//             to NUM_SINKS branches. A branch takes part only when its config
//             enable is set and bit SEL_BIT of its select field is set.
//             Lockstep mode: the word moves only when every active branch is
//             ready in the same cycle. Eager mode: each branch's acceptance
//             is registered, so branches may take the word on different
//             cycles; the source retires the word once all active branches
//             have it.
//  Ports    : clk, reset (async, active high)
//             in_valid / in_data / in_ready    source side
//             sink_en, sink_sel, eager_mode    static branch configuration
//             flush                            sync clear of acceptance state
//                                              and stall counter
//             out_valid / out_data / out_ready per-branch sink side
//             busy                             word partially delivered
//             stall_cnt                        saturating stall-cycle counter
//  Options  : FANOUT_STALL_CNT_EN - when defined, stall_cnt counts cycles
//             with in_valid & ~in_ready; otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module eager_fanout_fork #(
    parameter int NUM_SINKS  = 20,
    parameter int SEL_WIDTH  = 8,
    parameter int SEL_BIT    = 4,
    parameter int DATA_WIDTH = 17
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    input  logic [NUM_SINKS-1:0]           sink_en,
    input  logic [NUM_SINKS*SEL_WIDTH-1:0] sink_sel,
    input  logic                           eager_mode,
    input  logic                           flush,
    output logic [NUM_SINKS-1:0]           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic [NUM_SINKS-1:0]           out_ready,
    output logic                           busy,
    output logic [15:0]                    stall_cnt
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PARTIAL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SINKS-1:0]   done_q, done_d;
    logic [NUM_SINKS-1:0]   active;
    logic [NUM_SINKS-1:0]   pass;
    logic [NUM_SINKS-1:0]   taken;
    logic                   retire;

    // Only one bit of each select field is meaningful here.
    logic                   unused_sel;
    assign unused_sel = ^sink_sel;

    for (genvar i = 0; i < NUM_SINKS; i++) begin : g_active
        assign active[i] = sink_en[i] & sink_sel[i*SEL_WIDTH + SEL_BIT];
    end

    assign out_data = in_data;
    assign busy     = (state_q == PARTIAL);

    always_comb begin
        pass      = '0;
        in_ready  = 1'b0;
        out_valid = '0;
        taken     = '0;
        retire    = 1'b0;
        done_d    = done_q;
        state_d   = state_q;

        // A branch does not hold the source back if it is inactive, ready,
        // or (eager only) already holds the current word. Done bits of
        // branches deactivated mid-word are masked out by ~active.
        pass     = ~active | out_ready | (eager_mode ? done_q : '0);
        in_ready = &pass;

        if (eager_mode) begin
            out_valid = {NUM_SINKS{in_valid}} & active & ~done_q;
        end else begin
            out_valid = {NUM_SINKS{in_valid & in_ready}} & active;
        end

        taken  = out_valid & out_ready;
        retire = in_valid & in_ready;

        // Retire wins over accumulation; flush and retire both clear.
        if (!eager_mode || flush || retire) begin
            done_d = '0;
        end else begin
            done_d = done_q | taken;
        end

        if (!eager_mode || flush || retire) begin
            state_d = IDLE;
        end else if (|taken) begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

`ifdef FANOUT_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = 16'h0;
        end else if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eager_fanout_fork.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eager_fanout_fork
//  Purpose  : Self-checking bench for eager_fanout_fork (4 branches). Directed
//             scenarios followed by randomized traffic, compared each cycle
//             against a word-delivery reference model.
//  Options  : FANOUT_STALL_CNT_EN - enables the stall counter scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eager_fanout_fork;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int SB = 4;
    localparam int DW = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [N-1:0]      sink_en;
    logic [N*SW-1:0]   sink_sel;
    logic              eager_mode;
    logic              flush;
    logic [N-1:0]      out_valid;
    logic [DW-1:0]     out_data;
    logic [N-1:0]      out_ready;
    logic              busy;
    logic [15:0]       stall_cnt;

    eager_fanout_fork #(
        .NUM_SINKS (N),
        .SEL_WIDTH (SW),
        .SEL_BIT   (SB),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sink_en   (sink_en),
        .sink_sel  (sink_sel),
        .eager_mode(eager_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: which branches already hold the current word, and
    // the expected stall count.
    bit got_m [N];
    int stall_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_active(input int i);
        return sink_en[i] && sink_sel[i*SW + SB];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) got_m[i] = 1'b0;
    endtask

    // Expected outputs from the delivery bookkeeping and the current inputs.
    task automatic predict(output logic [N-1:0] ev, output logic er, output logic eb);
        er = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (is_active(i) && !(eager_mode && got_m[i]) && !out_ready[i]) er = 1'b0;
        end
        eb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (eager_mode) ev[i] = in_valid && is_active(i) && !got_m[i];
            else            ev[i] = in_valid && is_active(i) && er;
            eb = eb | got_m[i];
        end
    endtask

    function automatic logic [15:0] exp_stall();
`ifdef FANOUT_STALL_CNT_EN
        return stall_m[15:0];
`else
        return 16'h0;
`endif
    endfunction

    // Called right after inputs are driven on a falling edge: compare all
    // outputs, then advance the model across the next rising edge.
    task automatic cycle_check();
        logic [N-1:0] ev;
        logic er, eb;
        #2;
        predict(ev, er, eb);
        check_eq("out_valid", out_valid, ev);
        check_eq("in_ready",  in_ready,  er);
        check_eq("busy",      busy,      eb);
        check_eq("out_data",  out_data,  in_data);
        check_eq("stall_cnt", stall_cnt, exp_stall());
        @(posedge clk);
        if (flush || (in_valid && er)) begin
            model_clear();
        end else if (eager_mode) begin
            for (int i = 0; i < N; i++) if (ev[i] && out_ready[i]) got_m[i] = 1'b1;
        end
        if (flush)                                   stall_m = 0;
        else if (in_valid && !er && stall_m < 65535) stall_m++;
        @(negedge clk);
    endtask

    task automatic default_cfg();
        sink_en  = 4'b1111;
        sink_sel = {4{8'h10}};
        flush    = 1'b0;
    endtask

    task automatic randomize_inputs();
        in_valid  = ($urandom_range(0, 9) < 8);
        in_data   = DW'($urandom);
        out_ready = N'($urandom);
        flush     = ($urandom_range(0, 19) == 0);
        sink_en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       sink_sel[i*SW +: SW] = 8'h00;
                1:       sink_sel[i*SW +: SW] = 8'($urandom);
                default: sink_sel[i*SW +: SW] = 8'h10;
            endcase
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = '0;
        eager_mode = 1'b0;
        default_cfg();
        model_clear();
        stall_m = 0;
        #12;
        check_eq("rst_out_valid", out_valid, 4'b0000);
        check_eq("rst_busy",      busy,      1'b0);
        check_eq("rst_stall",     stall_cnt, 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Lockstep broadcast, then one branch not ready blocks everyone.
        in_valid  = 1'b1;
        in_data   = 17'h1A5A5;
        out_ready = 4'b1111;
        #1;
        check_eq("t1_ready", in_ready,  1'b1);
        check_eq("t1_valid", out_valid, 4'b1111);
        cycle_check();
        out_ready = 4'b1011;
        #1;
        check_eq("t1_block_ready", in_ready,  1'b0);
        check_eq("t1_block_valid", out_valid, 4'b0000);
        cycle_check();

        // Eager: two halves accept on consecutive cycles.
        flush = 1'b1;
        cycle_check();
        flush      = 1'b0;
        eager_mode = 1'b1;
        out_ready  = 4'b0011;
        #1;
        check_eq("t2_cy0_valid", out_valid, 4'b1111);
        check_eq("t2_cy0_ready", in_ready,  1'b0);
        check_eq("t2_cy0_busy",  busy,      1'b0);
        cycle_check();
        out_ready = 4'b1100;
        #1;
        check_eq("t2_cy1_valid", out_valid, 4'b1100);
        check_eq("t2_cy1_ready", in_ready,  1'b1);
        check_eq("t2_cy1_busy",  busy,      1'b1);
        cycle_check();
        out_ready = 4'b0000;
        #1;
        check_eq("t2_cy2_busy",  busy,      1'b0);
        check_eq("t2_cy2_valid", out_valid, 4'b1111);
        cycle_check();

        // No active branches: words drain, nothing is presented.
        sink_en = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            out_ready = N'($urandom);
            #1;
            check_eq("t3_ready", in_ready,  1'b1);
            check_eq("t3_valid", out_valid, 4'b0000);
            cycle_check();
        end
        default_cfg();

        // Reset pulse while a word is partially delivered.
        out_ready = 4'b0100;
        cycle_check();
        out_ready = 4'b0000;
        #1;
        check_eq("t4_pre_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("t4_rst_busy",  busy,      1'b0);
        check_eq("t4_rst_valid", out_valid, 4'b1111);
        check_eq("t4_rst_stall", stall_cnt, 16'h0);
        model_clear();
        stall_m = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t4_post_valid", out_valid, 4'b1111);
        cycle_check();

        // Deselect the only pending branch while partially delivered.
        out_ready = 4'b0111;
        cycle_check();
        out_ready = 4'b0000;
        sink_sel[3*SW +: SW] = 8'h00;
        #1;
        check_eq("t6_ready", in_ready, 1'b1);
        check_eq("t6_busy",  busy,     1'b1);
        cycle_check();
        #1;
        check_eq("t6_idle",  busy,     1'b0);
        cycle_check();
        default_cfg();

        // Flush together with retire.
        out_ready = 4'b0001;
        cycle_check();
        out_ready = 4'b1110;
        flush     = 1'b1;
        cycle_check();
        flush     = 1'b0;
        cycle_check();

        // Randomized eager traffic.
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            cycle_check();
        end

        // Randomized lockstep traffic; switch modes only across a flush.
        flush = 1'b1;
        cycle_check();
        eager_mode = 1'b0;
        for (int k = 0; k < 300; k++) begin
            randomize_inputs();
            cycle_check();
        end

`ifdef FANOUT_STALL_CNT_EN
        // Saturation of the stall counter, then flush clears it.
        default_cfg();
        flush     = 1'b1;
        cycle_check();
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 4'b0000;
        repeat (70000) @(negedge clk);
        stall_m = 65535;
        #1;
        check_eq("t5_sat", stall_cnt, 16'hFFFF);
        cycle_check();
        flush = 1'b1;
        cycle_check();
        flush = 1'b0;
        #1;
        check_eq("t5_flush", stall_cnt, 16'h0);
        cycle_check();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
